// File: rtl/dmem_responder_if.sv
// Processor data-memory port plus event/LED side channels of the responder.
// The processor side (or a bench) takes the master modport.
interface dmem_responder_if;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic        evt_valid;
  logic [7:0]  evt_data;
  logic        evt_ready;
  logic [31:0] led_out;

  modport master (
    output address_dmem, data, wren, evt_valid, evt_data,
    input  q_dmem, evt_ready, led_out
  );

  modport slave (
    input  address_dmem, data, wren, evt_valid, evt_data,
    output q_dmem, evt_ready, led_out
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus memory-mapped STATUS, EVT_POP, LED and CYCLES
// registers, serviced on the falling edge so reads land before the next rising edge.
module dmem_responder #(
  parameter int RAM_ADDR_BITS = 12
) (
  input logic            clock,
  input logic            reset,
  dmem_responder_if.slave bus
);

  localparam logic [31:0] ADDR_STATUS  = 32'hFFFF_FF00;
  localparam logic [31:0] ADDR_EVT_POP = 32'hFFFF_FF01;
  localparam logic [31:0] ADDR_LED     = 32'hFFFF_FF02;
  localparam logic [31:0] ADDR_CYCLES  = 32'hFFFF_FF03;
  localparam int          FIFO_DEPTH   = 8;

  // Address decode
  logic in_ram;
  logic hit_status;
  logic hit_pop;
  logic hit_led;
  logic hit_cycles;

  assign in_ram     = (bus.address_dmem >> RAM_ADDR_BITS) == 32'd0;
  assign hit_status = bus.address_dmem == ADDR_STATUS;
  assign hit_pop    = bus.address_dmem == ADDR_EVT_POP;
  assign hit_led    = bus.address_dmem == ADDR_LED;
  assign hit_cycles = bus.address_dmem == ADDR_CYCLES;

  // Word RAM: never reset, registered read gives the pre-write word
  logic [31:0]              ram [2**RAM_ADDR_BITS];
  logic [31:0]              ram_rd_reg;
  logic [RAM_ADDR_BITS-1:0] ram_idx;
  logic                     ram_we;

  assign ram_idx = bus.address_dmem[RAM_ADDR_BITS-1:0];
  assign ram_we  = reset && bus.wren && in_ram;

  always_ff @(negedge clock) begin
    if (ram_we) begin
      ram[ram_idx] <= bus.data;
    end
    ram_rd_reg <= ram[ram_idx];
  end

  // Event FIFO state
  logic [7:0] fifo_mem [FIFO_DEPTH];
  logic [2:0] rd_ptr_reg, rd_ptr_next;
  logic [2:0] wr_ptr_reg, wr_ptr_next;
  logic [3:0] count_reg, count_next;
  logic       pop_hit_reg, pop_hit_next;
  logic       fifo_full;
  logic       fifo_nonempty;
  logic       push;
  logic       pop_first;
  logic       pop;
  logic [7:0] head;
  logic [FIFO_DEPTH-1:0] slot_we;

  assign fifo_full     = count_reg == 4'd8;
  assign fifo_nonempty = count_reg != 4'd0;
  assign push          = reset && bus.evt_valid && !fifo_full;
  // Only the first edge of a run of EVT_POP reads pops, so a stalled load pops once.
  assign pop_first     = hit_pop && !bus.wren && !pop_hit_reg;
  assign pop           = pop_first && fifo_nonempty;
  assign head          = fifo_mem[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
      assign slot_we[gi] = push && (wr_ptr_reg == 3'(gi));
    end
  endgenerate

  always_ff @(negedge clock) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (slot_we[i]) begin
        fifo_mem[i] <= bus.evt_data;
      end
    end
  end

  // Register file and read path
  logic [31:0] led_reg, led_next;
  logic [31:0] cycles_reg, cycles_next;
  logic [31:0] mmio_rd_reg, mmio_rd_next;
  logic        sel_ram_reg, sel_ram_next;

  always_comb begin
    rd_ptr_next  = rd_ptr_reg;
    wr_ptr_next  = wr_ptr_reg;
    count_next   = count_reg;
    led_next     = led_reg;
    cycles_next  = cycles_reg + 32'd1;
    mmio_rd_next = 32'd0;
    sel_ram_next = in_ram;
    pop_hit_next = hit_pop && !bus.wren;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + 3'd1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 3'd1;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + 4'd1;
      2'b01:   count_next = count_reg - 4'd1;
      default: count_next = count_reg;
    endcase

    if (hit_led && bus.wren) begin
      led_next = bus.data;
    end
    if (hit_cycles && bus.wren) begin
      cycles_next = bus.data;
    end

    if (hit_status) begin
      mmio_rd_next = {27'd0, count_reg, fifo_nonempty};
    end else if (hit_pop) begin
      // Stalled repeats keep showing the byte popped on the first edge.
      if (bus.wren || pop_first) begin
        mmio_rd_next = fifo_nonempty ? {24'd0, head} : 32'd0;
      end else begin
        mmio_rd_next = mmio_rd_reg;
      end
    end else if (hit_led) begin
      mmio_rd_next = led_reg;
    end else if (hit_cycles) begin
      mmio_rd_next = cycles_reg;
    end
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg  <= 3'd0;
      wr_ptr_reg  <= 3'd0;
      count_reg   <= 4'd0;
      pop_hit_reg <= 1'b0;
      led_reg     <= 32'd0;
      cycles_reg  <= 32'd0;
      mmio_rd_reg <= 32'd0;
      sel_ram_reg <= 1'b0;
    end else begin
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
      count_reg   <= count_next;
      pop_hit_reg <= pop_hit_next;
      led_reg     <= led_next;
      cycles_reg  <= cycles_next;
      mmio_rd_reg <= mmio_rd_next;
      sel_ram_reg <= sel_ram_next;
    end
  end

  assign bus.q_dmem    = sel_ram_reg ? ram_rd_reg : mmio_rd_reg;
  assign bus.evt_ready = !fifo_full;
  assign bus.led_out   = led_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and random checks of dmem_responder against a queue/array reference model.
module tb_dmem_responder;

  localparam logic [31:0] STATUS = 32'hFFFF_FF00;
  localparam logic [31:0] POP    = 32'hFFFF_FF01;
  localparam logic [31:0] LED    = 32'hFFFF_FF02;
  localparam logic [31:0] CYC    = 32'hFFFF_FF03;
  localparam logic [31:0] UNMAP  = 32'h0000_2000;
  localparam int          RAM_WORDS = 4096;

  logic clock = 1'b0;
  logic reset;

  dmem_responder_if bus ();

  dmem_responder #(.RAM_ADDR_BITS(12)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [31:0] ram_m [int];
  logic [7:0]  fifo_q [$];
  logic [31:0] led_m;
  logic [31:0] cyc_m;
  logic [31:0] last_q;
  bit          prev_pop;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fifo_q.delete();
    led_m    = 32'd0;
    cyc_m    = 32'd0;
    last_q   = 32'd0;
    prev_pop = 1'b0;
  endtask

  // One falling edge: drive inputs, predict from the model, compare after the edge.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input bit we, input bit ev, input logic [7:0] ed);
    logic [31:0] exp;
    bit          known;
    bit          do_pop;
    int          sz;
    bus.address_dmem = a;
    bus.data         = d;
    bus.wren         = we;
    bus.evt_valid    = ev;
    bus.evt_data     = ed;
    exp    = 32'd0;
    known  = 1'b1;
    do_pop = 1'b0;
    sz     = fifo_q.size();
    if (a < RAM_WORDS) begin
      if (ram_m.exists(int'(a))) exp = ram_m[int'(a)];
      else known = 1'b0;
      if (we) ram_m[int'(a)] = d;
    end else if (a == STATUS) begin
      exp = {27'd0, 4'(sz), sz != 0};
    end else if (a == POP) begin
      if (we) exp = (sz != 0) ? {24'd0, fifo_q[0]} : 32'd0;
      else if (prev_pop) exp = last_q;
      else begin
        exp    = (sz != 0) ? {24'd0, fifo_q[0]} : 32'd0;
        do_pop = sz != 0;
      end
    end else if (a == LED) begin
      exp = led_m;
      if (we) led_m = d;
    end else if (a == CYC) begin
      exp = cyc_m;
    end
    cyc_m = (a == CYC && we) ? d : cyc_m + 32'd1;
    if (do_pop) void'(fifo_q.pop_front());
    if (ev && sz < 8) fifo_q.push_back(ed);
    prev_pop = (a == POP) && !we;
    last_q   = exp;

    @(negedge clock);
    #1;
    if (known) check({tag, "/q"}, bus.q_dmem, exp);
    check({tag, "/ready"}, {31'd0, bus.evt_ready}, {31'd0, fifo_q.size() < 8});
    check({tag, "/led"}, bus.led_out, led_m);
    $display("[TB] %-10s addr=%h we=%0d ev=%0d ed=%h q=%h rdy=%0d cnt=%0d",
             tag, a, we, ev, ed, bus.q_dmem, bus.evt_ready, fifo_q.size());
  endtask

  task automatic push_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) step("push", UNMAP, 32'd0, 1'b0, 1'b1, base + 8'(i));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/q"}, bus.q_dmem, 32'd0);
    check({tag, "/led"}, bus.led_out, 32'd0);
    check({tag, "/ready"}, {31'd0, bus.evt_ready}, 32'd1);
  endtask

  initial begin
    reset            = 1'b0;
    bus.address_dmem = 32'd0;
    bus.data         = 32'd0;
    bus.wren         = 1'b0;
    bus.evt_valid    = 1'b0;
    bus.evt_data     = 8'd0;
    model_reset();

    @(negedge clock);
    #1;
    check_reset_outputs("por");
    reset = 1'b1;

    // Known contents for the low RAM words
    for (int i = 0; i < 16; i++) step("fill", 32'(i), $urandom, 1'b1, 1'b0, 8'd0);

    // Read-before-write, then the new word
    step("wr5", 32'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 8'd0);
    step("rd5", 32'd5, 32'd0, 1'b0, 1'b0, 8'd0);
    check("rd5_const", bus.q_dmem, 32'hDEAD_BEEF);

    // Fill FIFO, overflow drop, ordered drain, empty pop
    push_n(8, 8'd1);
    check("full_ready", {31'd0, bus.evt_ready}, 32'd0);
    step("stat_full", STATUS, 32'd0, 1'b0, 1'b1, 8'd9);
    check("stat_full_const", bus.q_dmem, 32'h11);
    for (int i = 1; i <= 8; i++) begin
      step("pop", POP, 32'd0, 1'b0, 1'b0, 8'd0);
      check("pop_order", bus.q_dmem, 32'(i));
      step("gap", 32'd0, 32'd0, 1'b0, 1'b0, 8'd0);
    end
    step("stat_empty", STATUS, 32'd0, 1'b0, 1'b0, 8'd0);
    check("stat_empty_const", bus.q_dmem, 32'd0);
    step("pop_empty", POP, 32'd0, 1'b0, 1'b0, 8'd0);
    check("pop_empty_const", bus.q_dmem, 32'd0);
    step("gap", 32'd0, 32'd0, 1'b0, 1'b0, 8'd0);

    // Stalled pop address pops once
    push_n(3, 8'd10);
    for (int k = 0; k < 4; k++) step("hold", POP, 32'd0, 1'b0, 1'b0, 8'd0);
    step("stat_hold", STATUS, 32'd0, 1'b0, 1'b0, 8'd0);
    check("stat_hold_const", bus.q_dmem, 32'h5);
    for (int k = 0; k < 2; k++) begin
      step("pop", POP, 32'd0, 1'b0, 1'b0, 8'd0);
      step("gap", 32'd0, 32'd0, 1'b0, 1'b0, 8'd0);
    end

    // Simultaneous push and pop with 3 queued, then with 0 queued
    push_n(3, 8'd20);
    step("pp3", POP, 32'd0, 1'b0, 1'b1, 8'd23);
    check("pp3_head", bus.q_dmem, 32'd20);
    step("stat_pp3", STATUS, 32'd0, 1'b0, 1'b0, 8'd0);
    check("stat_pp3_const", bus.q_dmem, 32'h7);
    for (int i = 21; i <= 23; i++) begin
      step("pop", POP, 32'd0, 1'b0, 1'b0, 8'd0);
      check("pp3_drain", bus.q_dmem, 32'(i));
      step("gap", 32'd0, 32'd0, 1'b0, 1'b0, 8'd0);
    end
    step("pp0", POP, 32'd0, 1'b0, 1'b1, 8'd30);
    check("pp0_q", bus.q_dmem, 32'd0);
    step("stat_pp0", STATUS, 32'd0, 1'b0, 1'b0, 8'd0);
    check("stat_pp0_const", bus.q_dmem, 32'h3);
    step("pop", POP, 32'd0, 1'b0, 1'b0, 8'd0);
    check("pp0_drain", bus.q_dmem, 32'd30);
    step("gap", 32'd0, 32'd0, 1'b0, 1'b0, 8'd0);

    // Cycle counter write and wrap
    step("cyc_wr", CYC, 32'hFFFF_FFFE, 1'b1, 1'b0, 8'd0);
    step("cyc_rd", CYC, 32'd0, 1'b0, 1'b0, 8'd0);
    check("cyc_rd0", bus.q_dmem, 32'hFFFF_FFFE);
    step("cyc_rd", CYC, 32'd0, 1'b0, 1'b0, 8'd0);
    check("cyc_rd1", bus.q_dmem, 32'hFFFF_FFFF);
    step("cyc_rd", CYC, 32'd0, 1'b0, 1'b0, 8'd0);
    check("cyc_wrap", bus.q_dmem, 32'd0);

    // Mid-operation reset
    step("led_wr", LED, 32'h55, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) step("push_rd5", 32'd5, 32'd0, 1'b0, 1'b1, 8'(40 + i));
    check("pre_rst_led", bus.led_out, 32'h55);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    model_reset();
    bus.address_dmem = LED;
    bus.data         = 32'hAAAA_AAAA;
    bus.wren         = 1'b1;
    bus.evt_valid    = 1'b1;
    @(negedge clock);
    #1;
    check_reset_outputs("rst_hold");
    reset = 1'b1;
    step("stat_rst", STATUS, 32'd0, 1'b0, 1'b0, 8'd0);
    check("stat_rst_const", bus.q_dmem, 32'd0);
    step("rd5_rst", 32'd5, 32'd0, 1'b0, 1'b0, 8'd0);
    check("rd5_rst_const", bus.q_dmem, 32'hDEAD_BEEF);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int kind;
      kind = $urandom_range(0, 7);
      case (kind)
        0, 1:    a = 32'($urandom_range(0, 15));
        2:       a = STATUS;
        3, 4:    a = POP;
        5:       a = LED;
        6:       a = CYC;
        default: a = ($urandom_range(0, 1) == 0) ? 32'h0000_1000 : 32'hFFFF_FF04;
      endcase
      step("rand", a, $urandom, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
